esw_dispatch: RTL

Parametrised N-port packet dispatcher for the ESW pipeline; replaces the fixed local-plus-two-GOE-port output stage behind packet forwarding. It takes 134-bit packet words plus a per-packet action bitmap and replicates each packet to any subset of `PORT_NUM` output ports (unicast, multicast or drop). It forwards the end-of-packet valid status and keeps per-port and drop statistics.

---
 rtl/esw_pkg.sv | 24 ++
 rtl/esw_port_cnt.sv | 18 +
 rtl/esw_dispatch.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/esw_pkg.sv
// Shared definitions for the ESW packet dispatcher: word flags, FSM states
// and the packet word width.
package esw_pkg;

  localparam int DATA_W = 134;

  // Word-position flags carried in bits [133:132] of every packet word.
  localparam logic [1:0] HEAD = 2'b01;
  localparam logic [1:0] BODY = 2'b11;
  localparam logic [1:0] TAIL = 2'b10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FWD      = 2'd1,
    WAIT_VLD = 2'd2,
    DISCARD  = 2'd3
  } esw_state_e;

  // Extract the position flag from a packet word.
  function automatic logic [1:0] word_flag(input logic [DATA_W-1:0] w);
    return w[DATA_W-1 -: 2];
  endfunction

endpackage

// File: rtl/esw_port_cnt.sv
// Per-port good-packet counter: wraps modulo 2^CNT_W, advances on en.
module esw_port_cnt #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  // Count one good packet per enable pulse; natural overflow gives the wrap.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/esw_dispatch.sv
// N-port packet dispatcher: replicates each packet to the ports in its action
// bitmap (or drops it), forwards end-of-packet status and closes packets whose
// tail/status never arrived. Statistics counters are built only when the
// macro ESW_DISPATCH_CNT_EN is defined; otherwise the counter outputs are 0.
module esw_dispatch
  import esw_pkg::*;
#(
  parameter int PORT_NUM = 4,
  parameter int CNT_W    = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_data_wr,
  input  logic                      in_valid,
  input  logic                      in_valid_wr,
  input  logic [PORT_NUM-1:0]       in_action,
  input  logic                      in_action_wr,
  output logic [DATA_W-1:0]         out_data,
  output logic [PORT_NUM-1:0]       out_data_wr,
  output logic                      out_valid,
  output logic [PORT_NUM-1:0]       out_valid_wr,
  output logic [PORT_NUM*CNT_W-1:0] pktout_cnt,
  output logic [31:0]               drop_cnt
);

  esw_state_e state_q, state_d;
  logic [PORT_NUM-1:0] sel_q, sel_d;
  logic [PORT_NUM-1:0] act_q, act_d;
  logic                act_vld_q, act_vld_d;
  logic                tail_seen_q, tail_seen_d;

  // Skid copy of the whole input bundle. After a truncating head the input
  // stream runs one cycle late through this register until an idle input
  // cycle lets it catch up again.
  logic [DATA_W-1:0]   skid_data;
  logic                skid_data_wr, skid_valid, skid_valid_wr, skid_action_wr;
  logic [PORT_NUM-1:0] skid_action;
  logic                skid_mode_q;
  logic                from_skid, defer, start;

  logic [DATA_W-1:0]   e_data, data_d;
  logic                e_data_wr, e_valid, e_valid_wr, e_action_wr, e_head, valid_d;
  logic [PORT_NUM-1:0] e_action, data_wr_d, valid_wr_d, latch_bmp;
  logic [1:0]          e_flag;
  logic                latch_full;

  assign from_skid   = skid_mode_q & (skid_data_wr | skid_valid_wr | skid_action_wr);
  assign e_data      = from_skid ? skid_data      : in_data;
  assign e_data_wr   = from_skid ? skid_data_wr   : in_data_wr;
  assign e_valid     = from_skid ? skid_valid     : in_valid;
  assign e_valid_wr  = from_skid ? skid_valid_wr  : in_valid_wr;
  assign e_action    = from_skid ? skid_action    : in_action;
  assign e_action_wr = from_skid ? skid_action_wr : in_action_wr;
  assign e_flag      = word_flag(e_data);
  assign e_head      = e_data_wr && (e_flag == HEAD);

  // An action strobe in the same cycle as the head counts as a full latch.
  assign latch_full  = act_vld_q | e_action_wr;
  assign latch_bmp   = e_action_wr ? e_action : act_q;

  // Next-state and next-output decode for the dispatch FSM.
  // NOTE: every output of this block gets a default first so no latches are inferred.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    act_d       = act_q;
    act_vld_d   = act_vld_q;
    tail_seen_d = tail_seen_q;
    data_wr_d   = '0;
    valid_wr_d  = '0;
    data_d      = out_data;
    valid_d     = out_valid;
    start       = 1'b0;
    defer       = 1'b0;

    if (e_action_wr) begin
      act_vld_d = 1'b1;
      act_d     = e_action;
    end

    case (state_q)
      IDLE: start = e_head;
      FWD, WAIT_VLD: begin
        if (e_head) begin
          // Missing tail/status: close the open packet as bad, no data strobe.
          valid_wr_d = sel_q;
          valid_d    = 1'b0;
          if (from_skid) begin
            // Stream already one cycle late; start the new packet right away.
            start = 1'b1;
          end else begin
            // Replay the head (and its action strobe) from the skid next cycle.
            defer     = 1'b1;
            state_d   = IDLE;
            act_d     = act_q;
            act_vld_d = act_vld_q;
          end
        end else if (state_q == FWD) begin
          if (e_data_wr) begin
            data_wr_d = sel_q;
            data_d    = e_data;
            if (e_flag == TAIL) begin
              if (e_valid_wr) begin
                valid_wr_d = sel_q;
                valid_d    = e_valid;
                state_d    = IDLE;
              end else begin
                state_d = WAIT_VLD;
              end
            end
          end
        end else if (e_valid_wr) begin
          valid_wr_d = sel_q;
          valid_d    = e_valid;
          state_d    = IDLE;
        end
      end
      DISCARD: begin
        if (e_head) begin
          start = 1'b1;
        end else begin
          if (e_data_wr && (e_flag == TAIL)) tail_seen_d = 1'b1;
          if (e_valid_wr && tail_seen_d) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      act_vld_d   = 1'b0;
      tail_seen_d = 1'b0;
      if (latch_full && (latch_bmp != '0)) begin
        sel_d     = latch_bmp;
        data_wr_d = latch_bmp;
        data_d    = e_data;
        state_d   = FWD;
      end else begin
        state_d = DISCARD;
      end
    end
  end

  // FSM state, action latch, skid register and registered outputs.
  // NOTE: the skid word is a handful of flops, not a memory, so it is reset with everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      sel_q          <= '0;
      act_q          <= '0;
      act_vld_q      <= 1'b0;
      tail_seen_q    <= 1'b0;
      skid_data      <= '0;
      skid_data_wr   <= 1'b0;
      skid_valid     <= 1'b0;
      skid_valid_wr  <= 1'b0;
      skid_action    <= '0;
      skid_action_wr <= 1'b0;
      skid_mode_q    <= 1'b0;
      out_data       <= '0;
      out_data_wr    <= '0;
      out_valid      <= 1'b0;
      out_valid_wr   <= '0;
    end else begin
      state_q        <= state_d;
      sel_q          <= sel_d;
      act_q          <= act_d;
      act_vld_q      <= act_vld_d;
      tail_seen_q    <= tail_seen_d;
      skid_data      <= in_data;
      skid_data_wr   <= in_data_wr;
      skid_valid     <= in_valid;
      skid_valid_wr  <= in_valid_wr;
      skid_action    <= in_action;
      skid_action_wr <= in_action_wr;
      skid_mode_q    <= defer | from_skid;
      out_data       <= data_d;
      out_data_wr    <= data_wr_d;
      out_valid      <= valid_d;
      out_valid_wr   <= valid_wr_d;
    end
  end

`ifdef ESW_DISPATCH_CNT_EN
  logic drop_inc;

  // A head that starts a packet without a non-zero bitmap is a drop.
  assign drop_inc = start & ~(latch_full & (latch_bmp != '0));

  for (genvar i = 0; i < PORT_NUM; i++) begin : g_port_cnt
    esw_port_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (out_valid_wr[i] & out_valid),
      .cnt   (pktout_cnt[i*CNT_W +: CNT_W])
    );
  end

  // Saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt <= '0;
    else if (drop_inc && (drop_cnt != '1)) drop_cnt <= drop_cnt + 32'd1;
  end
`else
  assign pktout_cnt = '0;
  assign drop_cnt   = '0;
`endif

endmodule
